// File: rtl/mire_pkg.sv
// Shared types and constants for the mire_gen test-pattern writer:
// FSM states, pattern modes and the eight colour-bar RGB values.
package mire_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_VSTRIPE = 2'd0,
    MODE_HSTRIPE = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_BARS    = 2'd3
  } mode_t;

  localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
  localparam logic [23:0] RGB_BLACK = 24'h000000;

  // Colour bars, left to right
  localparam logic [23:0] BAR_RGB0 = 24'hFFFFFF;
  localparam logic [23:0] BAR_RGB1 = 24'hFFFF00;
  localparam logic [23:0] BAR_RGB2 = 24'h00FFFF;
  localparam logic [23:0] BAR_RGB3 = 24'h00FF00;
  localparam logic [23:0] BAR_RGB4 = 24'hFF00FF;
  localparam logic [23:0] BAR_RGB5 = 24'hFF0000;
  localparam logic [23:0] BAR_RGB6 = 24'h0000FF;
  localparam logic [23:0] BAR_RGB7 = 24'h000000;

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_RGB0;
      3'd1:    return BAR_RGB1;
      3'd2:    return BAR_RGB2;
      3'd3:    return BAR_RGB3;
      3'd4:    return BAR_RGB4;
      3'd5:    return BAR_RGB5;
      3'd6:    return BAR_RGB6;
      default: return BAR_RGB7;
    endcase
  endfunction

endpackage

// File: rtl/mire_pixel.sv
// Combinational pixel colour: (effective x, y, mode) -> 24-bit RGB.
module mire_pixel
  import mire_pkg::*;
#(
  parameter int HDISP  = 800,
  parameter int STRIPE = 4,
  parameter int XW     = 10,
  parameter int YW     = 9
) (
  input  logic [XW-1:0] i_xe,
  input  logic [YW-1:0] i_y,
  input  mode_t         i_mode,
  output logic [23:0]   o_rgb
);

  localparam int SW = $clog2(STRIPE);

  logic [XW-1:0] w_xs;
  logic [YW-1:0] w_ys;
  logic [2:0]    w_bar;

  assign w_xs = i_xe >> SW;
  assign w_ys = i_y >> SW;

  // Bar index by comparing against constant bar edges (avoids a divider)
  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(i_xe) >= k * (HDISP / 8)) w_bar = 3'(k);
    end
  end

  // Pattern select
  always_comb begin
    o_rgb = RGB_BLACK;
    case (i_mode)
      MODE_VSTRIPE: o_rgb = w_xs[0] ? RGB_WHITE : RGB_BLACK;
      MODE_HSTRIPE: o_rgb = w_ys[0] ? RGB_WHITE : RGB_BLACK;
      MODE_CHECKER: o_rgb = (w_xs[0] ^ w_ys[0]) ? RGB_WHITE : RGB_BLACK;
      MODE_BARS:    o_rgb = bar_rgb(w_bar);
      default:      o_rgb = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/mire_gen.sv
// Test-pattern generator writing one 32-bit pixel per Wishbone ack into a
// linear framebuffer, in bursts separated by a single idle cycle.
// Optional feature macro: MIRE_SCROLL_EN (horizontal scroll by one pixel per frame).
// Handshake: a write transfers on a clock edge where wshb_stb=1 and
// wshb_ack=1; while stb=1 and ack=0 the address and data hold steady.
module mire_gen
  import mire_pkg::*;
#(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter int          BURST_LEN = 64,
  parameter int          STRIPE    = 4,
  parameter logic [31:0] BASE_ADR  = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  output logic        frame_done,
  output logic [31:0] wshb_adr,
  output logic [31:0] wshb_dat_ms,
  output logic        wshb_we,
  output logic [3:0]  wshb_sel,
  output logic        wshb_stb,
  output logic        wshb_cyc,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  input  logic        wshb_ack,
  output logic [1:0]  o_dbg_state
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BURST_LEN - 1);

  state_t        r_state, w_state_nxt;
  logic [XW-1:0] r_x, w_x_nxt;
  logic [YW-1:0] r_y, w_y_nxt;
  logic [31:0]   r_adr, w_adr_nxt;
  logic [23:0]   r_dat;
  mode_t         r_mode, w_mode_nxt;
  logic [BW-1:0] r_bcnt, w_bcnt_nxt;
  logic          r_frame_end, w_frame_end_nxt;
  logic          w_frame_done;
  logic          w_last_x, w_last_pix;
  logic [XW-1:0] w_xe;
  logic [23:0]   w_rgb;

  assign w_last_x   = (r_x == X_LAST);
  assign w_last_pix = w_last_x && (r_y == Y_LAST);

  // Next-state, pixel walk and frame bookkeeping
  always_comb begin
    w_state_nxt     = r_state;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_adr_nxt       = r_adr;
    w_mode_nxt      = r_mode;
    w_bcnt_nxt      = r_bcnt;
    w_frame_end_nxt = r_frame_end;
    w_frame_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // IDLE is only ever held at pixel (0,0), so this is a frame start
        if (enable) begin
          w_state_nxt     = ST_BURST;
          w_mode_nxt      = mode_t'(mode);
          w_bcnt_nxt      = '0;
          w_frame_end_nxt = 1'b0;
        end
      end
      ST_BURST: begin
        if (wshb_ack) begin
          w_bcnt_nxt = r_bcnt + BW'(1);
          if (w_last_pix) begin
            w_x_nxt         = '0;
            w_y_nxt         = '0;
            w_adr_nxt       = BASE_ADR;
            w_frame_done    = 1'b1;
            w_frame_end_nxt = 1'b1;
            w_state_nxt     = ST_GAP;
          end else begin
            w_adr_nxt = r_adr + 32'd4;
            if (w_last_x) begin
              w_x_nxt = '0;
              w_y_nxt = r_y + YW'(1);
            end else begin
              w_x_nxt = r_x + XW'(1);
            end
            if (r_bcnt == B_LAST) w_state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        w_bcnt_nxt = '0;
        if (r_frame_end && !enable) begin
          w_state_nxt     = ST_IDLE;
          w_frame_end_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_BURST;
          if (r_frame_end) begin
            w_mode_nxt      = mode_t'(mode);
            w_frame_end_nxt = 1'b0;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef MIRE_SCROLL_EN
  logic [XW-1:0] r_off, w_off_nxt;
  logic [XW:0]   w_sum;

  // Scroll offset steps once per completed frame, modulo HDISP
  always_comb begin
    w_off_nxt = r_off;
    if (w_frame_done) w_off_nxt = (r_off == X_LAST) ? '0 : r_off + XW'(1);
  end

  assign w_sum = {1'b0, w_x_nxt} + {1'b0, w_off_nxt};
  assign w_xe  = (w_sum >= (XW+1)'(HDISP)) ? XW'(w_sum - (XW+1)'(HDISP)) : w_sum[XW-1:0];

  // Scroll offset register
  always_ff @(posedge clk) begin
    if (!rst_n) r_off <= '0;
    else        r_off <= w_off_nxt;
  end
`else
  assign w_xe = w_x_nxt;
`endif

  mire_pixel #(
    .HDISP (HDISP),
    .STRIPE(STRIPE),
    .XW    (XW),
    .YW    (YW)
  ) u_pixel (
    .i_xe  (w_xe),
    .i_y   (w_y_nxt),
    .i_mode(w_mode_nxt),
    .o_rgb (w_rgb)
  );

  // State and datapath registers; data is precomputed for the next pixel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_adr       <= BASE_ADR;
      r_dat       <= '0;
      r_mode      <= MODE_VSTRIPE;
      r_bcnt      <= '0;
      r_frame_end <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_adr       <= w_adr_nxt;
      r_dat       <= w_rgb;
      r_mode      <= w_mode_nxt;
      r_bcnt      <= w_bcnt_nxt;
      r_frame_end <= w_frame_end_nxt;
    end
  end

  assign wshb_stb    = (r_state == ST_BURST);
  assign wshb_cyc    = wshb_stb;
  assign wshb_adr    = r_adr;
  assign wshb_dat_ms = {8'h00, r_dat};
  assign wshb_we     = 1'b1;
  assign wshb_sel    = 4'hF;
  assign wshb_cti    = 3'd0;
  assign wshb_bte    = 2'd0;
  assign frame_done  = w_frame_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mire_gen.sv
// Directed bench for mire_gen at 16x4 pixels, bursts of 8, stripe 4.
// Build with MIRE_SCROLL_EN defined to also exercise the scroll offset.
module tb_mire_gen;

  localparam int          HD   = 16;
  localparam int          VD   = 4;
  localparam int          BL   = 8;
  localparam int          NPIX = HD * VD;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic        frame_done;
  logic [31:0] wshb_adr;
  logic [31:0] wshb_dat_ms;
  logic        wshb_we;
  logic [3:0]  wshb_sel;
  logic        wshb_stb;
  logic        wshb_cyc;
  logic [2:0]  wshb_cti;
  logic [1:0]  wshb_bte;
  logic        wshb_ack;
  logic [1:0]  dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  int g_off   = 0;

  mire_gen #(
    .HDISP    (HD),
    .VDISP    (VD),
    .BURST_LEN(BL),
    .STRIPE   (4),
    .BASE_ADR (BASE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mode       (mode),
    .frame_done (frame_done),
    .wshb_adr   (wshb_adr),
    .wshb_dat_ms(wshb_dat_ms),
    .wshb_we    (wshb_we),
    .wshb_sel   (wshb_sel),
    .wshb_stb   (wshb_stb),
    .wshb_cyc   (wshb_cyc),
    .wshb_cti   (wshb_cti),
    .wshb_bte   (wshb_bte),
    .wshb_ack   (wshb_ack),
    .o_dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Hand-written pattern table for a 16-pixel-wide screen, stripe 4
  function automatic logic [23:0] exp_pix(input int x, input int y, input logic [1:0] m, input int off);
    logic [23:0] bars [8];
    int xe;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    xe = (x + off) % HD;
    case (m)
      2'd0:    return ((xe / 4) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      2'd1:    return ((y / 4) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      2'd2:    return (((xe / 4) + (y / 4)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      default: return bars[xe / 2];
    endcase
  endfunction

  // Drive one full frame of acks and score every accepted write
  task automatic run_frame(input logic [1:0] m, input bit stall, input int chg_at,
                           input logic [1:0] chg_m, input int drop_at);
    int n, fd, cycles, low_run, backs, nbursts;
    bit was_stall, prev_stb;
    logic [31:0] padr, pdat;
    n = 0; fd = 0; cycles = 0; low_run = 0; backs = 0; nbursts = 0;
    was_stall = 1'b0; prev_stb = 1'b0; padr = '0; pdat = '0;
    while (n < NPIX && cycles < 4000) begin
      @(posedge clk); #1;
      cycles++;
      if (wshb_stb) begin
        if (was_stall) begin
          check("hold_adr", wshb_adr, padr);
          check("hold_dat", wshb_dat_ms, pdat);
        end
        if (!prev_stb) begin
          if (nbursts > 0) begin
            check("gap_len", 32'(low_run), 32'd1);
            check("burst_len", 32'(backs), 32'(BL));
          end
          nbursts++;
          backs = 0;
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      padr = wshb_adr;
      pdat = wshb_dat_ms;
      prev_stb = wshb_stb;
      wshb_ack = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      was_stall = wshb_stb && !wshb_ack;
      #1;
      if (frame_done) fd++;
      if (wshb_stb && wshb_ack) begin
        check("adr", wshb_adr, BASE + 32'(4 * n));
        check("dat", wshb_dat_ms, {8'h00, exp_pix(n % HD, n / HD, m, g_off)});
        check("consts", {28'h0, wshb_we, wshb_cyc, wshb_cti[0], wshb_bte[0]} | {wshb_sel, 28'h0},
              {4'hF, 24'h0, 4'b1100});
        check("frame_done", 32'(frame_done), 32'(n == NPIX - 1));
        backs++;
        n++;
        if (n == chg_at) mode = chg_m;
        if (n == drop_at) enable = 1'b0;
      end
    end
    check("frame_len", 32'(n), 32'(NPIX));
    check("last_burst", 32'(backs), 32'(BL));
    check("bursts", 32'(nbursts), 32'(NPIX / BL));
    check("fd_count", 32'(fd), 32'd1);
`ifdef MIRE_SCROLL_EN
    g_off = (g_off + 1) % HD;
`endif
  endtask

  initial begin
    int hi, acc, cyc;
    rst_n = 1'b0; enable = 1'b0; mode = 2'd0; wshb_ack = 1'b1;

    // Reset state, with ack held high to show it is ignored
    repeat (3) @(posedge clk);
    #1;
    check("rst_stb", 32'(wshb_stb), 32'd0);
    check("rst_adr", wshb_adr, BASE);
    check("rst_dat", wshb_dat_ms, 32'h0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // Out of reset but disabled: stays idle
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_stb", 32'(wshb_stb), 32'd0);

    // Vertical stripes, ack always high
    enable = 1'b1; mode = 2'd0;
    run_frame(2'd0, 1'b0, -1, 2'd0, -1);
    // Same frame under random stalls
    run_frame(2'd0, 1'b1, -1, 2'd0, -1);
    // Colour bars
    mode = 2'd3;
    run_frame(2'd3, 1'b0, -1, 2'd0, -1);
    // Mode switched to checker at pixel 10: ignored until next frame
    mode = 2'd0;
    run_frame(2'd0, 1'b0, 10, 2'd2, -1);
    run_frame(2'd2, 1'b1, -1, 2'd0, -1);
    // Horizontal stripes, then enable dropped mid-frame
    mode = 2'd1;
    run_frame(2'd1, 1'b1, -1, 2'd0, -1);
    run_frame(2'd1, 1'b0, -1, 2'd0, 20);
    @(posedge clk); #1;
    check("end_gap_state", 32'(dbg_state), 32'd2);
    check("end_gap_stb", 32'(wshb_stb), 32'd0);
    @(posedge clk); #1;
    check("end_idle_state", 32'(dbg_state), 32'd0);
    hi = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (wshb_stb) hi++;
    end
    check("idle_stb_low", 32'(hi), 32'd0);

`ifdef MIRE_SCROLL_EN
    // Enough frames to wrap the scroll offset back through zero
    enable = 1'b1; mode = 2'd0;
    repeat (HD) run_frame(2'd0, 1'b0, -1, 2'd0, -1);
`endif

    // Reset in the middle of a burst
    enable = 1'b1; mode = 2'd3;
    acc = 0; cyc = 0;
    while (acc < 5 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      wshb_ack = 1'b1;
      if (wshb_stb) acc++;
    end
    check("pre_rst_acks", 32'(acc), 32'd5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_stb", 32'(wshb_stb), 32'd0);
    check("mid_rst_adr", wshb_adr, BASE);
    check("mid_rst_dat", wshb_dat_ms, 32'h0);
    check("mid_rst_fd", 32'(frame_done), 32'd0);
    @(posedge clk); #1;
    check("mid_rst_stb2", 32'(wshb_stb), 32'd0);
    rst_n = 1'b1;
    g_off = 0;
    run_frame(2'd3, 1'b1, -1, 2'd0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mire_gen.md
MIRE_GEN -- requirements
Module: mire_gen

Interface
REQ-001 Parameter HDISP, default 800, active pixels per line; SHALL be a multiple of 8.
REQ-002 Parameter VDISP, default 480, active lines per frame.
REQ-003 Parameter BURST_LEN, default 64, acked writes per burst; SHALL be a power of two, 1..256.
REQ-004 Parameter STRIPE, default 4, stripe and checker cell size in pixels; SHALL be a power of two.
REQ-005 Parameter BASE_ADR, default 0, framebuffer byte base address; SHALL be 4-byte aligned.
REQ-006 Port clk, in, 1: single clock. Reset is synchronous and active-low.
REQ-007 Port rst_n, in, 1: synchronous reset, active low.
REQ-008 Port enable, in, 1: when high, the block starts or continues frames; sampled only at frame boundaries.
REQ-009 Port mode, in, 2: 0 vertical stripes, 1 horizontal stripes, 2 checker, 3 colour bars.
REQ-010 Port frame_done, out, 1: one-cycle pulse on the ack of the last pixel of a frame.
REQ-011 Ports wshb_adr out 32, wshb_dat_ms out 32, wshb_we out 1, wshb_sel out 4, wshb_stb out 1, wshb_cyc out 1, wshb_cti out 3, wshb_bte out 2: Wishbone master outputs.
REQ-012 Port wshb_ack, in, 1: Wishbone slave acknowledge.

Function
REQ-013 wshb_we SHALL be 1, wshb_sel 4'hF, wshb_cti 0, wshb_bte 0 (constants); wshb_cyc SHALL equal wshb_stb.
REQ-014 FSM states: IDLE, BURST, GAP. IDLE->BURST when enable=1; BURST->GAP on the BURST_LEN-th ack of a burst or the frame's last ack; GAP->BURST after exactly 1 cycle unless the frame completed and enable=0, in which case GAP->IDLE.
REQ-015 wshb_stb SHALL be 1 only in BURST; adr and dat SHALL remain stable while stb=1 and ack=0.
REQ-016 Pixel counters x (0..HDISP-1) and y (0..VDISP-1) SHALL advance by one pixel per ack only. x wraps at HDISP with y+1; y wraps at VDISP to 0 at frame end.
REQ-017 wshb_adr SHALL equal BASE_ADR + 4*(y*HDISP+x) of the current pixel, maintained incrementally with no multiplier; it returns to BASE_ADR at frame wrap.
REQ-018 wshb_dat_ms[31:24] SHALL be 0; [23:0] is RGB. mode 0: white (FFFFFF) if (xe/STRIPE) odd, else black. mode 1: the same on y. mode 2: white if ((xe/STRIPE) xor (y/STRIPE)) is odd. mode 3: 8 bars of width HDISP/8, ordered FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. xe is the effective x (REQ-026).
REQ-019 mode and enable SHALL be latched only when entering BURST at pixel (0,0); mid-frame changes SHALL be ignored.
REQ-020 A frame that has started SHALL always complete, even if enable falls mid-frame.
REQ-021 Bursts SHALL NOT straddle frames. When HDISP*VDISP is not a multiple of BURST_LEN, the last burst is short.
REQ-022 frame_done SHALL pulse in the same cycle as the final ack.

Reset
REQ-023 On rst_n=0 at a clk edge: state IDLE, x=y=0, wshb_adr=BASE_ADR, wshb_dat_ms=0, wshb_stb=0, frame_done=0, latched mode=0, scroll offset=0.
REQ-024 Reset mid-burst SHALL drop wshb_stb the next cycle. Acks arriving during or after reset SHALL be ignored.

Configuration
REQ-025 Macro MIRE_SCROLL_EN controls a horizontal scroll feature.
REQ-026 With MIRE_SCROLL_EN defined: a scroll offset register increments modulo HDISP at every frame end, and xe=(x+offset) mod HDISP. Without it: xe=x and no offset register exists.

Structure
REQ-027 Package mire_pkg SHALL hold the FSM state enum, the mode enum, and the eight colour-bar RGB constants.
REQ-028 Sub-module mire_pixel SHALL be purely combinational: (xe, y, mode) -> 24-bit RGB. The top level registers its result.

Verification
REQ-029 HDISP=16, VDISP=4, BURST_LEN=8, mode 0, ack always 1: 64 writes in 8 bursts, stb low 1 cycle between bursts, adr 0..252 step 4, dat FFFFFF for x in 4-7 and 12-15, frame_done pulses once.
REQ-030 Random ack stalls (~50%): adr and dat hold while stb=1 and ack=0; the write sequence is identical to REQ-029.
REQ-031 mode 3, HDISP=16: line 0 data pairs are FFFFFF,FFFFFF,FFFF00,FFFF00,...,000000.
REQ-032 mode changed 0->2 at pixel 10: frame continues in mode 0; the next frame starts in checker; pixel (4,0)=FFFFFF and (4,4)... with VDISP=8 gives 000000.
REQ-033 enable dropped mid-frame: frame completes, GAP->IDLE, stb stays 0. rst_n low mid-burst: stb=0 the next cycle and adr=BASE_ADR.
REQ-034 MIRE_SCROLL_EN, mode 0: pixel (0,0) of frame 2 = colour of x=1 in frame 1. After HDISP frames the offset wraps to 0.
